// File: rtl/spi_byte_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_byte_master
// Description : Byte-wide SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
//               One start moves one byte. The byte is shifted out on mosi and
//               sck while miso is captured. The received byte is returned on
//               data_out when busy falls. Chip select belongs to the loader
//               upstream and is not driven here.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   CLK_DIV   clk cycles per sck half-period (>= 1).
//             sck = clk / (2*CLK_DIV).
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   miso      serial data from flash
//   mosi      serial data to flash (registered)
//   sck       SPI clock, idle low (registered)
//   start     transfer request, sampled only while idle
//   busy      high while a transfer is in progress (registered)
//   data_in   byte to transmit, latched when start is accepted
//   data_out  last completely received byte (registered)
// ============================================================================
module spi_byte_master #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       miso,
    output logic       mosi,
    output logic       sck,
    input  logic       start,
    output logic       busy,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    // The divider needs at least one bit, even when CLK_DIV is 1.
    localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_DIV_W-1:0] r_div;
    logic [2:0]         r_bit;
    // Transmit bits still to be sent. Bit 7 goes straight to mosi when start
    // is accepted, so only the lower seven bits are held here.
    logic [6:0]         r_tx;
    logic [7:0]         r_rx;

    // A half-period ends on the edge where the divider reaches its last value.
    logic w_half_done;
    assign w_half_done = (r_div == c_DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_div    <= '0;
            r_bit    <= 3'd0;
            r_tx     <= 7'd0;
            r_rx     <= 8'd0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            data_out <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_tx    <= data_in[6:0];
                        mosi    <= data_in[7];
                        r_bit   <= 3'd0;
                        r_div   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_LOW;
                    end
                end

                ST_LOW: begin
                    if (w_half_done) begin
                        // Rising sck edge. The slave's bit has been stable for
                        // the whole low phase, so it is sampled here.
                        sck     <= 1'b1;
                        r_rx    <= {r_rx[6:0], miso};
                        r_div   <= '0;
                        r_state <= ST_HIGH;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                ST_HIGH: begin
                    if (w_half_done) begin
                        sck   <= 1'b0;
                        r_div <= '0;
                        if (r_bit == 3'd7) begin
                            // The eighth bit has been captured. The full byte
                            // is in r_rx and is published as busy falls.
                            data_out <= r_rx;
                            busy     <= 1'b0;
                            mosi     <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else begin
                            // The falling edge presents the next bit. It then
                            // has a full low phase of setup before the rise.
                            r_bit   <= r_bit + 3'd1;
                            mosi    <= r_tx[6];
                            r_tx    <= {r_tx[5:0], 1'b0};
                            r_state <= ST_LOW;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                default: begin
                    sck     <= 1'b0;
                    mosi    <= 1'b0;
                    busy    <= 1'b0;
                    r_div   <= '0;
                    r_bit   <= 3'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
